// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit between the EX/MEM and MEM/WB registers.
// Issues one req/ack data-memory access per load/store, stalls the pipeline until the
// access completes (or times out), builds store byte lanes and aligns/extends load data.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus request, misalign_o pulse) instead of silently truncating the address.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] ReadData_o,
    output logic        Stall_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       addr_q, wdata_q, read_data;
    logic [3:0]        be_q;
    logic              we_q, err_q;
    logic [2:0]        f3_q;

    logic              go, timeout;
    logic [1:0]        sz_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic              mis_d;

    // Access size: stores know only B/H/W, loads add the unsigned variants; anything else is a word.
    function automatic logic [1:0] size_of(input logic st, input logic [2:0] f3);
        logic [1:0] sz;
        sz = SZ_W;
        if (st) begin
            if (f3 == 3'b000)      sz = SZ_B;
            else if (f3 == 3'b001) sz = SZ_H;
        end else begin
            if (f3 == 3'b000 || f3 == 3'b100)      sz = SZ_B;
            else if (f3 == 3'b001 || f3 == 3'b101) sz = SZ_H;
        end
        return sz;
    endfunction

    // Pick the addressed byte/half out of the bus word and sign- or zero-extend it.
    function automatic logic [31:0] load_align(input logic [31:0] rd, input logic [1:0] a,
                                               input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Request decode: byte enables, replicated store lanes and misalignment for the incoming op.
    always_comb begin
        go      = MemRead_i | MemWrite_i;
        sz_d    = size_of(MemWrite_i, funct3_i);
        be_d    = 4'b1111;
        wdata_d = WriteData_i;
        if (MemWrite_i) begin
            case (sz_d)
                SZ_B: begin
                    be_d    = 4'b0001 << Addr_i[1:0];
                    wdata_d = {4{WriteData_i[7:0]}};
                end
                SZ_H: begin
                    be_d    = Addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{WriteData_i[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = WriteData_i;
                end
            endcase
        end
`ifdef MISALIGN_TRAP_EN
        mis_d = ((sz_d == SZ_H) && Addr_i[0]) || ((sz_d == SZ_W) && (Addr_i[1:0] != 2'b00));
`else
        mis_d = 1'b0;
`endif
    end

    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic for the IDLE -> REQ -> DONE access sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = mis_d ? S_DONE : S_REQ;
            S_REQ:   if (dmem_ack_i || timeout) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; an async reset drops an in-flight request immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Latch the bus request, count REQ cycles, capture load data and flag errors.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt       <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            read_data <= '0;
            err_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (go && mis_d) begin
                        read_data <= '0;
`ifdef MISALIGN_TRAP_EN
                        misalign_o <= 1'b1;
`endif
                    end else if (go) begin
                        addr_q  <= Addr_i;
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        we_q    <= MemWrite_i;
                        f3_q    <= funct3_i;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dmem_ack_i) begin
                        if (!we_q) read_data <= load_align(dmem_rdata_i, addr_q[1:0], f3_q);
                    end else if (timeout) begin
                        read_data <= '0;
                        err_q     <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign dmem_req_o   = (state == S_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign ReadData_o   = read_data;
    assign err_o        = err_q;
    assign Stall_o      = RESET & (((state == S_IDLE) & go) | (state == S_REQ));

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a behavioural load/store model and a
// bus responder that acks after a chosen delay (or never, to force a timeout).
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] Addr_i = '0, WriteData_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic [31:0] ReadData_o;
    logic        Stall_o, err_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = '0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .CLK(CLK), .RESET(RESET),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
        .Addr_i(Addr_i), .WriteData_i(WriteData_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .ReadData_o(ReadData_o), .Stall_o(Stall_o),
`ifdef MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .err_o(err_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_bytes(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a,
                                               input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * a)) & 32'hFF;
        h = (rdata >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // One complete MEM-stage access; delay < 0 means the responder never acks.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int delay);
        int          sz, a, stalls, reqs, ereqs;
        logic        mis, eerr, tmo;
        logic [31:0] ebe, ewd, eres;
        a   = int'(addr[1:0]);
        sz  = size_bytes(wr, f3);
        ebe = 32'hF;
        ewd = wd;
        if (wr) begin
            if (sz == 1)      begin ebe = 32'd1 << a;                   ewd = wd[7:0] * 32'h0101_0101; end
            else if (sz == 2) begin ebe = (a >= 2) ? 32'hC : 32'h3;     ewd = wd[15:0] * 32'h0001_0001; end
        end
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (sz == 2 && (a % 2) != 0) || (sz == 4 && a != 0);
`endif
        tmo  = !mis && (delay < 0 || delay >= TO);
        eerr = tmo;
        if (mis)      begin eres = 32'd0; ereqs = 0; end
        else if (tmo) begin eres = 32'd0; ereqs = TO; end
        else          begin eres = wr ? exp_rd : model_load(f3, a, rdata); ereqs = delay + 1; end

        @(negedge CLK);
        MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; Addr_i = addr; WriteData_i = wd;
        #1;
        chk("stall_on_issue", Stall_o, 1);
        stalls = Stall_o ? 1 : 0;
        reqs   = 0;
        for (int cyc = 0; cyc < TO + 8; cyc++) begin
            @(posedge CLK); #1;
            dmem_ack_i = 1'b0;
            if (!dmem_req_o) break;
            reqs++;
            if (Stall_o) stalls++;
            if (reqs == 1) begin
                chk("bus_addr", dmem_addr_o, {addr[31:2], 2'b00});
                chk("bus_be", dmem_be_o, ebe);
                chk("bus_we", dmem_we_o, wr);
                if (wr) chk("bus_wdata", dmem_wdata_o, ewd);
            end
            if (delay >= 0 && reqs - 1 == delay) begin
                dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
            end else begin
                dmem_rdata_i = $urandom;
            end
        end
        chk("req_dropped", dmem_req_o, 0);
        chk("req_cycles", reqs, ereqs);
        chk("stall_cycles", stalls, 1 + ereqs);
        chk("done_stall", Stall_o, 0);
        chk("read_data", ReadData_o, eres);
        chk("err_in_done", err_o, eerr);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_in_done", misalign_o, mis);
`endif
        exp_rd = eres;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        dmem_ack_i = 1'($urandom_range(0, 1));
        dmem_rdata_i = $urandom;
        @(posedge CLK); #1;
        dmem_ack_i = 1'b0;
        chk("idle_hold", ReadData_o, exp_rd);
        chk("err_pulse_end", err_o, 0);
        chk("idle_req", dmem_req_o, 0);
        chk("idle_stall", Stall_o, 0);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_pulse_end", misalign_o, 0);
`endif
    endtask

    // Async reset while a request is outstanding.
    task automatic reset_mid_req();
        @(negedge CLK);
        MemRead_i = 1'b1; funct3_i = 3'b010; Addr_i = 32'h40;
        @(posedge CLK); #1;
        chk("rst_req_before", dmem_req_o, 1);
        #2 RESET = 1'b0;
        #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_stall", Stall_o, 0);
        chk("rst_rdata", ReadData_o, 0);
        chk("rst_err", err_o, 0);
        exp_rd = 32'd0;
        @(negedge CLK);
        MemRead_i = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_req", dmem_req_o, 0);
        chk("post_rst_stall", Stall_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, r, dly;
        #1;
        chk("reset_req", dmem_req_o, 0);
        chk("reset_stall", Stall_o, 0);
        chk("reset_rdata", ReadData_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_be", dmem_be_o, 0);
        chk("reset_addr", dmem_addr_o, 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);        // LB sign-extend
        reset_mid_req();
        run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0);        // SH upper half
        run_txn(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 32'hBEEF_0000, 3);          // LHU with waits
        run_txn(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, -1);               // LW timeout
        run_txn(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, TO - 1);   // ack on last cycle
        run_txn(1'b0, 1'b1, 3'b010, 32'h101, 32'hCAFE_F00D, 32'h0, 0);        // SW unaligned
        run_txn(1'b1, 1'b1, 3'b000, 32'h7, 32'h0000_00A5, 32'h0, 1);          // both: store wins

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            if (r == 0)      dly = -1;
            else if (r == 1) dly = TO - 1;
            else             dly = $urandom_range(0, 3);
            run_txn(op != 1, op != 0, 3'($urandom), $urandom, $urandom, $urandom, dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
